// File: rtl/uart_reg_bridge_if.sv
// Signal bundle between the UART byte-stream bridge and its environment:
// rx byte sink, tx byte source and the 8-bit ack-handshake register bus.
interface uart_reg_bridge_if;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_error;

    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;

    logic [7:0] bus_address;
    logic       bus_write;
    logic [7:0] bus_writedata;
    logic       bus_read;
    logic [7:0] bus_readdata;
    logic       bus_ack;

    // Bridge side
    modport master (
        output in_ready,
        input  in_valid, in_data, in_error,
        input  out_ready,
        output out_valid, out_data,
        output bus_address, bus_write, bus_writedata, bus_read,
        input  bus_readdata, bus_ack
    );

    // Environment side (rx phy, tx phy, register slave)
    modport slave (
        input  in_ready,
        output in_valid, in_data, in_error,
        output out_ready,
        input  out_valid, out_data,
        input  bus_address, bus_write, bus_writedata, bus_read,
        output bus_readdata, bus_ack
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// Decodes 'W' addr data / 'R' addr host frames into single register bus
// cycles and returns exactly one response byte per finished or aborted frame.
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter logic [7:0]  ACK_CODE       = 8'h06,
    parameter logic [7:0]  NAK_CODE       = 8'h15
) (
    input  logic              clk,
    input  logic              reset,
    uart_reg_bridge_if.master bif
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUSWR, BUSRD, RESP} state_t;

    localparam logic [7:0]  CMD_WRITE    = 8'h57;
    localparam logic [7:0]  CMD_READ     = 8'h52;
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state_reg;
    logic        wr_reg;
    logic [15:0] cnt_reg;
    logic        out_valid_reg;
    logic [7:0]  out_data_reg;
    logic        bus_write_reg;
    logic        bus_read_reg;
    logic [7:0]  bus_address_reg;
    logic [7:0]  bus_writedata_reg;

    logic accept;
    logic in_err;

    assign bif.in_ready = (state_reg == IDLE) || (state_reg == ADDR) || (state_reg == DATA);
    assign accept       = bif.in_valid && bif.in_ready;
    assign in_err       = |bif.in_error;

    assign bif.out_valid     = out_valid_reg;
    assign bif.out_data      = out_data_reg;
    assign bif.bus_write     = bus_write_reg;
    assign bif.bus_read      = bus_read_reg;
    assign bif.bus_address   = bus_address_reg;
    assign bif.bus_writedata = bus_writedata_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            wr_reg            <= 1'b0;
            cnt_reg           <= '0;
            out_valid_reg     <= 1'b0;
            out_data_reg      <= '0;
            bus_write_reg     <= 1'b0;
            bus_read_reg      <= 1'b0;
            bus_address_reg   <= '0;
            bus_writedata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg <= TIMEOUT_LOAD;
                        // A flagged byte is rejected before it is decoded
                        if (in_err) begin
                            state_reg     <= RESP;
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= NAK_CODE;
                        end else if (bif.in_data == CMD_WRITE) begin
                            wr_reg    <= 1'b1;
                            state_reg <= ADDR;
                        end else if (bif.in_data == CMD_READ) begin
                            wr_reg    <= 1'b0;
                            state_reg <= ADDR;
                        end else begin
                            state_reg     <= RESP;
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= NAK_CODE;
                        end
                    end
                end

                ADDR: begin
                    if (accept) begin
                        cnt_reg <= TIMEOUT_LOAD;
                        if (in_err) begin
                            state_reg     <= RESP;
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= NAK_CODE;
                        end else begin
                            bus_address_reg <= bif.in_data;
                            if (wr_reg) begin
                                state_reg <= DATA;
                            end else begin
                                state_reg    <= BUSRD;
                                bus_read_reg <= 1'b1;
                            end
                        end
                    end else if (TIMEOUT_EN) begin
                        // Host went quiet mid-frame: drop it without answering
                        if (cnt_reg <= 16'd1) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg - 16'd1;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        cnt_reg <= TIMEOUT_LOAD;
                        if (in_err) begin
                            state_reg     <= RESP;
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= NAK_CODE;
                        end else begin
                            bus_writedata_reg <= bif.in_data;
                            state_reg         <= BUSWR;
                            bus_write_reg     <= 1'b1;
                        end
                    end else if (TIMEOUT_EN) begin
                        if (cnt_reg <= 16'd1) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg - 16'd1;
                        end
                    end
                end

                BUSWR, BUSRD: begin
                    // An ack in the final counted cycle still wins over the timeout
                    if (bif.bus_ack) begin
                        bus_write_reg <= 1'b0;
                        bus_read_reg  <= 1'b0;
                        state_reg     <= RESP;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= (state_reg == BUSWR) ? ACK_CODE : bif.bus_readdata;
                    end else if (TIMEOUT_EN) begin
                        if (cnt_reg <= 16'd1) begin
                            bus_write_reg <= 1'b0;
                            bus_read_reg  <= 1'b0;
                            cnt_reg       <= '0;
                            state_reg     <= RESP;
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= NAK_CODE;
                        end else begin
                            cnt_reg <= cnt_reg - 16'd1;
                        end
                    end
                end

                RESP: begin
                    if (bif.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed plus randomized frames against a register-file reference model;
// a responder process plays rx/tx phy monitor and register slave.
module tb_uart_reg_bridge;
    localparam int         T   = 20;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic clk = 1'b0;
    logic reset;

    uart_reg_bridge_if bif();

    uart_reg_bridge #(.TIMEOUT_CYCLES(T), .ACK_CODE(ACK), .NAK_CODE(NAK)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_delay = 1;
    int wr_cycles = 0;
    int rd_cycles = 0;
    int unstable = 0;
    int out_rd = 0;
    int bus_rd = 0;
    logic [7:0]  slave_mem [256];
    logic [7:0]  model_mem [256];
    logic [7:0]  out_q [$];
    logic [16:0] bus_q [$];

    // Environment: register slave with programmable ack delay, tx monitor
    initial begin
        int age;
        logic [7:0] a0, d0;
        age = 0; a0 = '0; d0 = '0;
        bif.bus_ack = 1'b0;
        bif.bus_readdata = '0;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i * 7 + 3);
        forever begin
            @(negedge clk);
            if (bif.out_valid && bif.out_ready && !reset) out_q.push_back(bif.out_data);
            if (bif.bus_write || bif.bus_read) begin
                if (bif.bus_write) wr_cycles++; else rd_cycles++;
                if (age == 0) begin
                    a0 = bif.bus_address; d0 = bif.bus_writedata;
                end else if (bif.bus_address !== a0 || (bif.bus_write && bif.bus_writedata !== d0)) begin
                    unstable++;
                end
                if (age == ack_delay) begin
                    bif.bus_ack = 1'b1;
                    bif.bus_readdata = slave_mem[bif.bus_address];
                    if (bif.bus_write) begin
                        slave_mem[bif.bus_address] = bif.bus_writedata;
                        bus_q.push_back({1'b1, bif.bus_address, bif.bus_writedata});
                    end else begin
                        bus_q.push_back({1'b0, bif.bus_address, bif.bus_readdata});
                    end
                end else begin
                    bif.bus_ack = 1'b0;
                    bif.bus_readdata = 8'($urandom);
                end
                age++;
            end else begin
                age = 0;
                // Stray acks outside a bus cycle must be ignored
                bif.bus_ack = 1'($urandom_range(0, 1));
                bif.bus_readdata = 8'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] err);
        int n = 0;
        bif.in_valid = 1'b1; bif.in_data = b; bif.in_error = err;
        while (!bif.in_ready && n < 100) begin tick(); n++; end
        if (n >= 100) check("in_ready_wait", 0, 1);
        tick();
        bif.in_valid = 1'b0; bif.in_error = '0; bif.in_data = 8'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic expect_resp(input logic [7:0] exp, input string tag);
        int n = 0;
        while (out_q.size() <= out_rd && n < 200) begin tick(); n++; end
        if (out_q.size() <= out_rd) check({tag, "_noresp"}, 0, 1);
        else begin
            check(tag, 32'(out_q[out_rd]), 32'(exp));
            out_rd++;
        end
        repeat (3) tick();
        check({tag, "_count"}, out_q.size(), out_rd);
    endtask

    task automatic expect_bus(input logic wr, input logic [7:0] a, input logic [7:0] d, input string tag);
        if (bus_q.size() <= bus_rd) check({tag, "_missing"}, 0, 1);
        else begin
            check(tag, 32'(bus_q[bus_rd]), {15'd0, wr, a, d});
            bus_rd++;
        end
        check({tag, "_single"}, bus_q.size(), bus_rd);
    endtask

    initial begin
        int w0, r0, n, kind, hold, pos;
        logic [7:0] a, d, c, exp;
        logic [1:0] e;

        reset = 1'b1;
        bif.in_valid = 1'b0; bif.in_data = '0; bif.in_error = '0; bif.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(i * 7 + 3);
        repeat (3) tick();
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_out_data", bif.out_data, 0);
        check("rst_bus_write", bif.bus_write, 0);
        check("rst_bus_read", bif.bus_read, 0);
        check("rst_bus_address", bif.bus_address, 0);
        check("rst_bus_writedata", bif.bus_writedata, 0);
        check("rst_in_ready", bif.in_ready, 1);
        reset = 1'b0;
        tick();

        // Write 57,12,A5 with ack one cycle after the strobe rises
        ack_delay = 1; w0 = wr_cycles;
        send_byte(8'h57, 0); send_byte(8'h12, 0); send_byte(8'hA5, 0);
        expect_resp(ACK, "wr_resp");
        check("wr_strobe_cycles", wr_cycles - w0, 2);
        expect_bus(1'b1, 8'h12, 8'hA5, "wr_bus");
        model_mem[8'h12] = 8'hA5;

        // Seed 34 with 5A, then read it back with a 3-cycle strobe
        ack_delay = 0;
        send_byte(8'h57, 0); send_byte(8'h34, 0); send_byte(8'h5A, 0);
        expect_resp(ACK, "wr0_resp");
        expect_bus(1'b1, 8'h34, 8'h5A, "wr0_bus");
        model_mem[8'h34] = 8'h5A;
        ack_delay = 2; r0 = rd_cycles;
        send_byte(8'h52, 0); send_byte(8'h34, 0);
        expect_resp(8'h5A, "rd_resp");
        check("rd_strobe_cycles", rd_cycles - r0, 3);
        expect_bus(1'b0, 8'h34, 8'h5A, "rd_bus");

        // Unknown command and framing error on the address byte
        w0 = wr_cycles; r0 = rd_cycles;
        send_byte(8'h41, 0);
        expect_resp(NAK, "unk_resp");
        send_byte(8'h57, 0); send_byte(8'h20, 2'b10);
        expect_resp(NAK, "err_resp");
        check("unk_err_no_strobe", (wr_cycles - w0) + (rd_cycles - r0), 0);
        check("unk_err_no_bus", bus_q.size(), bus_rd);

        // Inter-byte timeout, then a clean read
        ack_delay = 1;
        send_byte(8'h57, 0); send_byte(8'h10, 0);
        repeat (25) tick();
        check("ib_to_silent", out_q.size(), out_rd);
        check("ib_to_no_bus", bus_q.size(), bus_rd);
        send_byte(8'h52, 0); send_byte(8'h00, 0);
        expect_resp(model_mem[0], "ib_to_next_rd");
        expect_bus(1'b0, 8'h00, model_mem[0], "ib_to_next_bus");

        // Bus timeout: ack never comes
        ack_delay = -1; r0 = rd_cycles;
        send_byte(8'h52, 0); send_byte(8'h44, 0);
        expect_resp(NAK, "bus_to_resp");
        check("bus_to_strobe_cycles", rd_cycles - r0, T);
        check("bus_to_no_bus", bus_q.size(), bus_rd);

        // Back-pressure on the response
        ack_delay = 1; bif.out_ready = 1'b0;
        send_byte(8'h57, 0); send_byte(8'h66, 0); send_byte(8'hC3, 0);
        n = 0;
        while (!bif.out_valid && n < 100) begin tick(); n++; end
        check("bp_valid_seen", bif.out_valid, 1);
        for (int i = 0; i < 50; i++) begin
            check("bp_hold", {bif.out_valid, bif.out_data, bif.in_ready}, {1'b1, ACK, 1'b0});
            tick();
        end
        bif.out_ready = 1'b1; tick(); bif.out_ready = 1'b0;
        repeat (3) tick();
        check("bp_one_xfer", out_q.size(), out_rd + 1);
        if (out_q.size() > out_rd) begin
            check("bp_data", 32'(out_q[out_rd]), 32'(ACK));
            out_rd = out_q.size();
        end
        check("bp_valid_low", bif.out_valid, 0);
        bif.out_ready = 1'b1;
        expect_bus(1'b1, 8'h66, 8'hC3, "bp_bus");
        model_mem[8'h66] = 8'hC3;

        // Reset during a write bus cycle
        ack_delay = -1;
        send_byte(8'h57, 0); send_byte(8'h77, 0); send_byte(8'h99, 0);
        n = 0;
        while (!bif.bus_write && n < 100) begin tick(); n++; end
        check("rst_mid_strobe_seen", bif.bus_write, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_bus_write", bif.bus_write, 0);
        check("rst_mid_out_valid", bif.out_valid, 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check("rst_mid_in_ready", bif.in_ready, 1);
        check("rst_mid_no_resp", out_q.size(), out_rd);
        check("rst_mid_no_bus", bus_q.size(), bus_rd);
        ack_delay = 1;
        send_byte(8'h52, 0); send_byte(8'h77, 0);
        expect_resp(model_mem[8'h77], "rst_mid_next_rd");
        expect_bus(1'b0, 8'h77, model_mem[8'h77], "rst_mid_next_bus");

        // Randomized frames against the register-file model
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 3);
            a = 8'($urandom); d = 8'($urandom);
            hold = $urandom_range(0, 5);
            ack_delay = $urandom_range(0, 5);
            bif.out_ready = (hold == 0);
            exp = NAK;
            case (kind)
                0: begin
                    send_byte(8'h57, 0); gap(); send_byte(a, 0); gap(); send_byte(d, 0);
                    exp = ACK;
                end
                1: begin
                    send_byte(8'h52, 0); gap(); send_byte(a, 0);
                    exp = model_mem[a];
                end
                2: begin
                    c = 8'($urandom);
                    while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
                    send_byte(c, 0);
                end
                default: begin
                    c = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
                    pos = (c == 8'h57) ? $urandom_range(0, 2) : $urandom_range(0, 1);
                    e = 2'($urandom_range(1, 3));
                    send_byte(c, (pos == 0) ? e : 2'b00);
                    if (pos >= 1) begin gap(); send_byte(a, (pos == 1) ? e : 2'b00); end
                    if (pos == 2) begin gap(); send_byte(d, e); end
                end
            endcase
            repeat (hold) tick();
            bif.out_ready = 1'b1;
            expect_resp(exp, "rand_resp");
            if (kind == 0) begin
                expect_bus(1'b1, a, d, "rand_wr_bus");
                model_mem[a] = d;
            end else if (kind == 1) begin
                expect_bus(1'b0, a, exp, "rand_rd_bus");
            end else begin
                check("rand_no_bus", bus_q.size(), bus_rd);
            end
        end

        check("strobe_stable", unstable, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Byte-stream command responder sitting between uart_phy_rxd (ST out) and uart_phy_txd (ST in).
- Decodes short host frames into single-byte register write/read cycles on a simple 8-bit ack-handshake bus.
- Returns exactly one response byte per completed or aborted frame.
- Gives a UART host console access to on-chip control registers.

Parameters:
- TIMEOUT_CYCLES, 10000: inter-byte and bus-ack timeout in clk cycles. Valid range 1..65535; 0 disables both timeouts.
- ACK_CODE, 8'h06: response byte for a successful write.
- NAK_CODE, 8'h15: response byte for an error, unknown command or bus timeout.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_ready  output  1  ST sink ready; connect to rx phy out_ready.
- in_valid  input  1  ST sink valid.
- in_data  input  8  received byte.
- in_error  input  2  rx phy error flags: [0] overflow, [1] framing.
- out_ready  input  1  ST source ready; connect to tx phy in_ready.
- out_valid  output  1  response byte valid.
- out_data  output  8  response byte.
- bus_address  output  8  register address.
- bus_write  output  1  write strobe; held until bus_ack.
- bus_writedata  output  8  write data.
- bus_read  output  1  read strobe; held until bus_ack.
- bus_readdata  input  8  read data; sampled in the cycle bus_ack=1.
- bus_ack  input  1  slave completion.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. Reset mid-operation aborts immediately with no response.
- Reset values: state=IDLE, out_valid=0, out_data=0, bus_write=0, bus_read=0, bus_address=0, bus_writedata=0, timeout counter=0.
- in_ready is combinational: 1 in IDLE, ADDR and DATA; 0 otherwise. It is therefore 1 during reset.
- A byte is accepted on in_valid & in_ready.
- Frames:
  - Write: 8'h57 ('W'), addr, data -> bus write, then ACK_CODE.
  - Read: 8'h52 ('R'), addr -> bus read, then the bus_readdata byte.
- IDLE:
  - Accept 'W' -> ADDR with wr flag set.
  - Accept 'R' -> ADDR with wr flag clear.
  - Any other byte -> RESP with out_data=NAK_CODE.
- ADDR: the accepted byte loads bus_address.
  - wr flag set -> DATA.
  - wr flag clear -> BUSRD; bus_read=1 from the next cycle.
- DATA: the accepted byte loads bus_writedata -> BUSWR; bus_write=1 from the next cycle.
- BUSWR / BUSRD:
  - Strobe is held with address and data stable until bus_ack=1 is sampled.
  - Next cycle: strobe=0, state=RESP, out_valid=1.
  - out_data is ACK_CODE for a write, or the bus_readdata captured in the ack cycle for a read.
  - bus_ack outside BUSWR/BUSRD is ignored.
- RESP:
  - out_valid=1 with out_data stable until out_ready=1.
  - In that cycle the byte transfers; the next cycle has out_valid=0 and state=IDLE.
  - Exactly one transfer per frame.
- in_error:
  - Any accepted byte with in_error != 0, in any of IDLE/ADDR/DATA, discards the frame (no bus cycle) -> RESP with NAK_CODE.
  - in_error takes priority over command decode.
- Timeout counter (16 bit):
  - Loaded with TIMEOUT_CYCLES on each accepted byte and on entry to BUSWR/BUSRD; decrements by 1 per cycle in ADDR, DATA, BUSWR and BUSRD.
  - Inter-byte timeout: reaching 0 in ADDR or DATA -> IDLE silently, no response.
  - Bus timeout: reaching 0 in BUSWR or BUSRD -> strobe=0 next cycle -> RESP with NAK_CODE. A late bus_ack is ignored.
  - bus_ack in the same cycle the counter hits 0 counts as success.
  - TIMEOUT_CYCLES=0: counter inactive, waits indefinitely.
- Back-pressure: bytes arriving while in_ready=0 remain in the rx phy. The bridge does not drop them; the rx phy flags overflow if a second byte arrives.

Test Plan:
- Write: stream 57,12,A5 with out_ready=1 and bus_ack one cycle after bus_write rises. Expect:
  - bus_write high for exactly 2 cycles, with bus_address=12 and bus_writedata=A5.
  - Then a single out byte 06.
- Read: stream 52,34 with bus_ack after 3 cycles and bus_readdata=5A in the ack cycle. Expect:
  - bus_read high for 3 cycles, bus_address=34.
  - Out byte 5A; bus_readdata changing after ack has no effect.
- Unknown command and error byte:
  - Byte 41 -> out byte 15, no bus strobe.
  - 'W' with in_error=2'b10 on the addr byte -> out byte 15, no bus_write.
- Timeouts with TIMEOUT_CYCLES=20:
  - 'W', addr, then silence for 25 cycles -> back to IDLE, no out byte; a following 52,00 frame completes normally.
  - Read with bus_ack never asserted -> bus_read drops after 20 cycles, out byte 15.
- Back-pressure and reset:
  - Hold out_ready=0 for 50 cycles after a write completes -> out_valid=1 and out_data=06 stable, in_ready=0; out_ready pulse -> exactly one transfer.
  - Assert reset during BUSWR -> bus_write=0 and out_valid=0 immediately; state IDLE after release.
